data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master arbiter and sequencer for the CPU data bus. It sits between the CPU load/store port (master 0) and a program-loader/debug port (master 1), and a single data-memory/peripheral slave. It grants one transaction at a time, registers the address, data and length onto the slave port, and waits for the slave handshake. It then returns read data and a completion pulse to the owning master, and aborts transactions the slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, 255: max BUSY cycles before abort; 0 disables the timeout.
- clk  in  1  clock, rising-edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_m0_req / i_m1_req  in  1  request; held high with stable payload until matching done.
- i_m0_address / i_m1_address  in  32  byte address.
- i_m0_wr_data / i_m1_wr_data  in  32  write data.
- i_m0_write_length / i_m1_write_length  in  3  access size code, passed through unchanged.
- i_m0_wr_enable / i_m1_wr_enable  in  1  1 = write, 0 = read.
- o_m0_done / o_m1_done  out  1  one-cycle completion pulse.
- o_m0_err / o_m1_err  out  1  valid with done; 1 = timed out.
- o_rd_data  out  32  read data, valid with either done.
- o_bus_valid  out  1  slave request.
- i_bus_ready  in  1  slave accepts/completes in the cycle valid&ready.
- o_bus_address, o_bus_wr_data  out  32  registered payload.
- o_bus_write_length  out  3  registered payload.
- o_bus_wr_enable  out  1  registered, gated by o_bus_valid.
- i_bus_read_data  in  32  sampled in the valid&ready cycle.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If any req is high, pick an owner, capture that master's payload into the bus registers, set o_bus_valid and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - On valid&ready: capture i_bus_read_data into o_rd_data (writes capture 0), clear valid, set owner done with err=0, go to DONE.
  - On timeout: clear valid, o_rd_data=0, set owner done with err=1, go to DONE.
- **DONE**
  - Holds one cycle.
  - All requests are ignored.
  - Go to IDLE.
- **Pick rule**
  - Only one req high: that master wins.
  - Both high: see Configuration.
  - The last-owner register updates on every grant.
- **Timeout**
  - The counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - Abort when count == TIMEOUT_CYCLES-1, i.e. after TIMEOUT_CYCLES cycles of valid without ready.
  - Ready in the abort cycle wins: normal completion, err=0.
- Payload changes on a non-owner's inputs have no effect. Owner payload changes after grant are ignored because the payload is registered.
- o_bus_wr_enable = captured wr_enable & o_bus_valid.

## Timing
- **Reset values:** state IDLE, o_bus_valid 0, all bus payload outputs 0, o_mX_done 0, o_mX_err 0, o_rd_data 0, last-owner = master 1, so master 0 wins first under round-robin. Counter 0.
- **Reset mid-transaction:** abandons the transaction immediately. No done is issued.
- **Latency:**
  - req sampled high at edge N gives o_bus_valid high after edge N.
  - Ready at cycle N+1 gives done high after edge N+1, for one cycle.
  - IDLE again after edge N+2.
  - Minimum period is 3 cycles per transaction.
- A master keeping req high through done is re-arbitrated in IDLE. Its new payload must be valid by the IDLE cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- DATA_BUS_ARB_ROUND_ROBIN_EN
  - Defined: on simultaneous requests, the master that did not own the previous grant wins.
  - Undefined: fixed priority, master 0 always wins, and the last-owner register is omitted.

## Structure
- The shared parameters header holds:
  - state encoding: ARB_IDLE, ARB_BUSY, ARB_DONE;
  - master IDs: ARB_M0, ARB_M1;
  - the write_length codes already shared with the CPU bus.
- Sub-module bus_arb_pick: combinational owner selection from (req0, req1, last_owner). It contains the macro-dependent logic.
- The timeout counter stays inline.

## Test plan
- **Single read, m0:** addr 0x0000_0010, slave ready 1 cycle after valid, read data 0xDEAD_BEEF.
  - o_m0_done pulses at N+2 with o_rd_data 0xDEAD_BEEF and err 0.
  - o_m1_done stays 0.
- **Single write, m1:** addr 0x0000_0040, data 0x1234_5678, length 3'b010.
  - Bus outputs show exactly these values with wr_enable 1 while valid.
  - o_m1_done pulses once.
- **Simultaneous requests, 4 transactions, ROUND_ROBIN_EN defined:**
  - Grant order is m0, m1, m0, m1.
  - Without the macro, the order is m0, m0, m0, m0.
- **Timeout, TIMEOUT_CYCLES=4, ready never asserted:**
  - valid high for exactly 4 cycles.
  - Owner done=1, err=1, o_rd_data 0.
  - A subsequent transaction completes normally.
- **Ready coincides with the abort cycle:** completion with err=0 and the slave data returned.
- **i_reset_n low for 1 cycle mid-BUSY:**
  - All outputs return to reset values asynchronously.
  - No done pulse.
  - The next request is granted with the normal latency.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the CPU data-bus arbiter: state encoding, master IDs,
// write_length codes shared with the CPU bus, and the captured-payload record.
// Optional feature macro: DATA_BUS_ARB_ROUND_ROBIN_EN (round-robin tie-break).
package data_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam logic [2:0] ARB_WL_BYTE = 3'b000;
  localparam logic [2:0] ARB_WL_HALF = 3'b001;
  localparam logic [2:0] ARB_WL_WORD = 3'b010;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wr_data;
    logic [2:0]  write_length;
    logic        wr_enable;
  } arb_payload_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational owner selection for the two-master data-bus arbiter.
// Optional feature macro: DATA_BUS_ARB_ROUND_ROBIN_EN. When defined, a tie goes
// to the master that did not win the previous grant; otherwise master 0 wins.
module bus_arb_pick
  import data_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant,
  output logic owner
);

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  // Grant whoever asks; on a tie alternate away from the previous owner.
  always_comb begin
    grant = req0 | req1;
    owner = ARB_M0;
    if (req0 && req1) begin
      owner = (last_owner == ARB_M0) ? ARB_M1 : ARB_M0;
    end else if (req1) begin
      owner = ARB_M1;
    end
  end
`else
  // Fixed priority: master 1 only wins when master 0 is not requesting.
  always_comb begin
    grant = req0 | req1;
    owner = ARB_M0;
    if (!req0 && req1) begin
      owner = ARB_M1;
    end
  end

  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter and sequencer for the CPU data bus: grants one master,
// registers its payload onto the slave port, waits for valid&ready (or aborts
// after TIMEOUT_CYCLES), then pulses done/err back to the owner.
// Optional feature macro: DATA_BUS_ARB_ROUND_ROBIN_EN (round-robin tie-break).
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_wr_data,
  input  logic [2:0]  i_m0_write_length,
  input  logic        i_m0_wr_enable,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_wr_data,
  input  logic [2:0]  i_m1_write_length,
  input  logic        i_m1_wr_enable,
  output logic        o_m0_done,
  output logic        o_m0_err,
  output logic        o_m1_done,
  output logic        o_m1_err,
  output logic [31:0] o_rd_data,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wr_data,
  output logic [2:0]  o_bus_write_length,
  output logic        o_bus_wr_enable,
  input  logic [31:0] i_bus_read_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  arb_payload_t     pay_q, pay_d;
  logic             valid_q, valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             m0_done_q, m0_done_d, m1_done_q, m1_done_d;
  logic             m0_err_q, m0_err_d, m1_err_q, m1_err_d;

  logic         last_owner;
  logic         pick_grant;
  logic         pick_owner;
  arb_payload_t pick_payload;
  logic         timeout_hit;

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  assign last_owner = last_owner_q;
`else
  assign last_owner = ARB_M1;
`endif

  bus_arb_pick u_pick (
    .req0       (i_m0_req),
    .req1       (i_m1_req),
    .last_owner (last_owner),
    .grant      (pick_grant),
    .owner      (pick_owner)
  );

  assign pick_payload = (pick_owner == ARB_M1)
    ? '{i_m1_address, i_m1_wr_data, i_m1_write_length, i_m1_wr_enable}
    : '{i_m0_address, i_m0_wr_data, i_m0_write_length, i_m0_wr_enable};

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // Next-state, payload capture, timeout counting and completion signalling.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    pay_d     = pay_q;
    valid_d   = valid_q;
    rd_data_d = rd_data_q;
    m0_done_d = 1'b0;
    m1_done_d = 1'b0;
    m0_err_d  = 1'b0;
    m1_err_d  = 1'b0;
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_grant) begin
          state_d = ARB_BUSY;
          owner_d = pick_owner;
          pay_d   = pick_payload;
          valid_d = 1'b1;
          cnt_d   = '0;
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
          last_owner_d = pick_owner;
`endif
        end
      end
      ARB_BUSY: begin
        if (i_bus_ready) begin
          state_d   = ARB_DONE;
          valid_d   = 1'b0;
          rd_data_d = pay_q.wr_enable ? 32'h0 : i_bus_read_data;
          m0_done_d = (owner_q == ARB_M0);
          m1_done_d = (owner_q == ARB_M1);
        end else if (timeout_hit) begin
          state_d   = ARB_DONE;
          valid_d   = 1'b0;
          rd_data_d = 32'h0;
          m0_done_d = (owner_q == ARB_M0);
          m1_done_d = (owner_q == ARB_M1);
          m0_err_d  = (owner_q == ARB_M0);
          m1_err_d  = (owner_q == ARB_M1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_M0;
      cnt_q     <= '0;
      pay_q     <= '{32'h0, 32'h0, ARB_WL_BYTE, 1'b0};
      valid_q   <= 1'b0;
      rd_data_q <= 32'h0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      pay_q     <= pay_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
      m0_done_q <= m0_done_d;
      m1_done_q <= m1_done_d;
      m0_err_q  <= m0_err_d;
      m1_err_q  <= m1_err_d;
    end
  end

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  // Last-owner memory starts at master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_owner_q <= ARB_M1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign o_m0_done          = m0_done_q;
  assign o_m1_done          = m1_done_q;
  assign o_m0_err           = m0_err_q;
  assign o_m1_err           = m1_err_q;
  assign o_rd_data          = rd_data_q;
  assign o_bus_valid        = valid_q;
  assign o_bus_address      = pay_q.address;
  assign o_bus_wr_data      = pay_q.wr_data;
  assign o_bus_write_length = pay_q.write_length;
  assign o_bus_wr_enable    = pay_q.wr_enable & valid_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter (TIMEOUT_CYCLES = 4): table of
// transactions with hand-computed results, plus a mid-transaction reset sequence.
module tb_data_bus_arbiter;
  import data_bus_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        i_reset_n;
  logic        i_m0_req, i_m1_req;
  logic [31:0] i_m0_address, i_m1_address, i_m0_wr_data, i_m1_wr_data;
  logic [2:0]  i_m0_write_length, i_m1_write_length;
  logic        i_m0_wr_enable, i_m1_wr_enable;
  logic        o_m0_done, o_m0_err, o_m1_done, o_m1_err;
  logic [31:0] o_rd_data;
  logic        o_bus_valid;
  logic        i_bus_ready;
  logic [31:0] o_bus_address, o_bus_wr_data;
  logic [2:0]  o_bus_write_length;
  logic        o_bus_wr_enable;
  logic [31:0] i_bus_read_data;

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [2:0]  m0_len;
    logic        m0_wr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [2:0]  m1_len;
    logic        m1_wr;
    int          ready_at;
    logic [31:0] slave_data;
    logic        exp_owner;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_valid_cycles;
  } vec_t;

  vec_t vecs[11];
  int   checks;
  int   errors;

  data_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .i_reset_n          (i_reset_n),
    .i_m0_req           (i_m0_req),
    .i_m0_address       (i_m0_address),
    .i_m0_wr_data       (i_m0_wr_data),
    .i_m0_write_length  (i_m0_write_length),
    .i_m0_wr_enable     (i_m0_wr_enable),
    .i_m1_req           (i_m1_req),
    .i_m1_address       (i_m1_address),
    .i_m1_wr_data       (i_m1_wr_data),
    .i_m1_write_length  (i_m1_write_length),
    .i_m1_wr_enable     (i_m1_wr_enable),
    .o_m0_done          (o_m0_done),
    .o_m0_err           (o_m0_err),
    .o_m1_done          (o_m1_done),
    .o_m1_err           (o_m1_err),
    .o_rd_data          (o_rd_data),
    .o_bus_valid        (o_bus_valid),
    .i_bus_ready        (i_bus_ready),
    .o_bus_address      (o_bus_address),
    .o_bus_wr_data      (o_bus_wr_data),
    .o_bus_write_length (o_bus_write_length),
    .o_bus_wr_enable    (o_bus_wr_enable),
    .i_bus_read_data    (i_bus_read_data)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(
    input logic r0, input logic r1,
    input logic [31:0] a0, input logic [31:0] d0, input logic [2:0] l0, input logic w0,
    input logic [31:0] a1, input logic [31:0] d1, input logic [2:0] l1, input logic w1,
    input int rdy, input logic [31:0] sd,
    input logic own, input logic [31:0] erd, input logic err, input int vc);
    vec_t v;
    v.m0_req = r0;   v.m1_req = r1;
    v.m0_addr = a0;  v.m0_wdata = d0; v.m0_len = l0; v.m0_wr = w0;
    v.m1_addr = a1;  v.m1_wdata = d1; v.m1_len = l1; v.m1_wr = w1;
    v.ready_at = rdy; v.slave_data = sd;
    v.exp_owner = own; v.exp_rd = erd; v.exp_err = err; v.exp_valid_cycles = vc;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    i_m0_req          = v.m0_req;
    i_m0_address      = v.m0_addr;
    i_m0_wr_data      = v.m0_wdata;
    i_m0_write_length = v.m0_len;
    i_m0_wr_enable    = v.m0_wr;
    i_m1_req          = v.m1_req;
    i_m1_address      = v.m1_addr;
    i_m1_wr_data      = v.m1_wdata;
    i_m1_write_length = v.m1_len;
    i_m1_wr_enable    = v.m1_wr;
    i_bus_ready       = 1'b0;
    i_bus_read_data   = v.slave_data;
  endtask

  task automatic check_output(input int idx, input vec_t v, input int valid_cycles,
                              input logic [31:0] exp_addr);
    logic own_done, oth_done, own_err, oth_err;
    own_done = v.exp_owner ? o_m1_done : o_m0_done;
    oth_done = v.exp_owner ? o_m0_done : o_m1_done;
    own_err  = v.exp_owner ? o_m1_err  : o_m0_err;
    oth_err  = v.exp_owner ? o_m0_err  : o_m1_err;
    check32($sformatf("v%0d owner_done", idx), {31'h0, own_done}, 32'h1);
    check32($sformatf("v%0d other_done", idx), {31'h0, oth_done}, 32'h0);
    check32($sformatf("v%0d owner_err", idx), {31'h0, own_err}, {31'h0, v.exp_err});
    check32($sformatf("v%0d other_err", idx), {31'h0, oth_err}, 32'h0);
    check32($sformatf("v%0d rd_data", idx), o_rd_data, v.exp_rd);
    check32($sformatf("v%0d valid_after", idx), {31'h0, o_bus_valid}, 32'h0);
    check32($sformatf("v%0d wr_en_after", idx), {31'h0, o_bus_wr_enable}, 32'h0);
    check32($sformatf("v%0d valid_cycles", idx), valid_cycles, v.exp_valid_cycles);
    check32($sformatf("v%0d addr_held", idx), o_bus_address, exp_addr);
  endtask

  // One complete transaction from the table, starting at a negedge in IDLE.
  task automatic run_vector(input int idx);
    vec_t        v;
    logic [31:0] ea, ed;
    logic [2:0]  el;
    logic        ew;
    int          valid_cycles;
    bit          got;
    v  = vecs[idx];
    ea = v.exp_owner ? v.m1_addr  : v.m0_addr;
    ed = v.exp_owner ? v.m1_wdata : v.m0_wdata;
    el = v.exp_owner ? v.m1_len   : v.m0_len;
    ew = v.exp_owner ? v.m1_wr    : v.m0_wr;
    apply_stimulus(v);
    @(posedge clk);
    @(negedge clk);
    check32($sformatf("v%0d valid_grant", idx), {31'h0, o_bus_valid}, 32'h1);
    check32($sformatf("v%0d bus_addr", idx), o_bus_address, ea);
    check32($sformatf("v%0d bus_wdata", idx), o_bus_wr_data, ed);
    check32($sformatf("v%0d bus_len", idx), {29'h0, o_bus_write_length}, {29'h0, el});
    check32($sformatf("v%0d bus_wr_en", idx), {31'h0, o_bus_wr_enable}, {31'h0, ew});
    i_m0_address = ~i_m0_address;
    i_m1_address = ~i_m1_address;
    valid_cycles = 0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_m0_done || o_m1_done) begin
        got = 1'b1;
        break;
      end
      valid_cycles += o_bus_valid ? 1 : 0;
      i_bus_ready = (c == v.ready_at);
      @(negedge clk);
    end
    i_bus_ready = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL v%0d done_timeout no done within 20 cycles", idx);
    end else begin
      check_output(idx, v, valid_cycles, ea);
    end
    i_m0_req = 1'b0;
    i_m1_req = 1'b0;
    @(negedge clk);
    check32($sformatf("v%0d done_pulse_end", idx), {30'h0, o_m0_done, o_m1_done}, 32'h0);
  endtask

  // Main sequence: reset checks, vector table, then mid-BUSY reset.
  initial begin
    int seen_done;
    logic own2, own3, own4, own5;
    checks = 0;
    errors = 0;
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
    own2 = ARB_M0; own3 = ARB_M1; own4 = ARB_M0; own5 = ARB_M1;
`else
    own2 = ARB_M0; own3 = ARB_M0; own4 = ARB_M0; own5 = ARB_M0;
`endif
    vecs[0]  = mk(1, 0, 32'h0000_0010, 32'h0, ARB_WL_WORD, 0, 32'h0, 32'h0, ARB_WL_BYTE, 0,
                  0, 32'hDEAD_BEEF, ARB_M0, 32'hDEAD_BEEF, 0, 1);
    vecs[1]  = mk(0, 1, 32'h0, 32'h0, ARB_WL_BYTE, 0, 32'h0000_0040, 32'h1234_5678, ARB_WL_WORD, 1,
                  2, 32'h9999_9999, ARB_M1, 32'h0, 0, 3);
    vecs[2]  = mk(1, 1, 32'h0000_0100, 32'h0, ARB_WL_HALF, 0, 32'h0000_0200, 32'h0, ARB_WL_BYTE, 0,
                  0, 32'hA000_0002, own2, 32'hA000_0002, 0, 1);
    vecs[3]  = mk(1, 1, 32'h0000_0104, 32'h0, ARB_WL_HALF, 0, 32'h0000_0204, 32'h0, ARB_WL_BYTE, 0,
                  0, 32'hA000_0003, own3, 32'hA000_0003, 0, 1);
    vecs[4]  = mk(1, 1, 32'h0000_0108, 32'h0, ARB_WL_HALF, 0, 32'h0000_0208, 32'h0, ARB_WL_BYTE, 0,
                  0, 32'hA000_0004, own4, 32'hA000_0004, 0, 1);
    vecs[5]  = mk(1, 1, 32'h0000_010C, 32'h0, ARB_WL_HALF, 0, 32'h0000_020C, 32'h0, ARB_WL_BYTE, 0,
                  0, 32'hA000_0005, own5, 32'hA000_0005, 0, 1);
    vecs[6]  = mk(1, 0, 32'h0000_0300, 32'h0, ARB_WL_WORD, 0, 32'h0, 32'h0, ARB_WL_BYTE, 0,
                  99, 32'hFFFF_FFFF, ARB_M0, 32'h0, 1, TO);
    vecs[7]  = mk(0, 1, 32'h0, 32'h0, ARB_WL_BYTE, 0, 32'h0000_0304, 32'h0, ARB_WL_WORD, 0,
                  1, 32'hCAFE_F00D, ARB_M1, 32'hCAFE_F00D, 0, 2);
    vecs[8]  = mk(1, 0, 32'h0000_0308, 32'h0, ARB_WL_WORD, 0, 32'h0, 32'h0, ARB_WL_BYTE, 0,
                  TO - 1, 32'h0BAD_F00D, ARB_M0, 32'h0BAD_F00D, 0, TO);
    vecs[9]  = mk(0, 1, 32'h0, 32'h0, ARB_WL_BYTE, 0, 32'h0000_0400, 32'h0000_00AA, ARB_WL_BYTE, 1,
                  0, 32'h7777_7777, ARB_M1, 32'h0, 0, 1);
    vecs[10] = mk(1, 1, 32'h0000_0600, 32'h0, ARB_WL_WORD, 0, 32'h0000_0700, 32'h0, ARB_WL_WORD, 0,
                  0, 32'h1357_9BDF, ARB_M0, 32'h1357_9BDF, 0, 1);

    i_reset_n = 1'b0;
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    check32("reset valid", {31'h0, o_bus_valid}, 32'h0);
    check32("reset addr", o_bus_address, 32'h0);
    check32("reset wdata", o_bus_wr_data, 32'h0);
    check32("reset len_wren", {28'h0, o_bus_write_length, o_bus_wr_enable}, 32'h0);
    check32("reset done_err", {28'h0, o_m0_done, o_m0_err, o_m1_done, o_m1_err}, 32'h0);
    check32("reset rd_data", o_rd_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vector(i);
    end

    apply_stimulus(mk(0, 1, 0, 0, 0, 0, 32'h0000_0500, 32'h0, ARB_WL_WORD, 0, 0, 32'h5555_AAAA,
                      0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    check32("rst_mid valid_before", {31'h0, o_bus_valid}, 32'h1);
    @(negedge clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check32("rst_mid valid", {31'h0, o_bus_valid}, 32'h0);
    check32("rst_mid addr", o_bus_address, 32'h0);
    check32("rst_mid rd_data", o_rd_data, 32'h0);
    check32("rst_mid done_err", {28'h0, o_m0_done, o_m0_err, o_m1_done, o_m1_err}, 32'h0);
    i_m1_req = 1'b0;
    @(negedge clk);
    i_reset_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen_done += (o_m0_done || o_m1_done) ? 1 : 0;
    end
    check32("rst_mid no_done", seen_done, 32'h0);

    run_vector(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
